// File: rtl/vga_text_pixel_pipe.sv
// Text-mode pixel pipeline: VRAM fetch -> font lookup -> palette colour, 4 CLK from draw_x/draw_y to RGB/hs/vs.
// No backpressure: advances every CLK; palette is latched on the vs_in falling edge so a frame never tears.
module vga_text_pixel_pipe #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic        blank_in,
    input  logic        hs_in,
    input  logic        vs_in,
    output logic [9:0]  vram_addr,
    input  logic [31:0] vram_rdata,
    input  logic [31:0] ctrl_reg,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hs,
    output logic        vs,
    output logic        frame_toggle
);

    logic [6:0]  col_w;
    logic [5:0]  row_w;
    logic [11:0] idx_w;
    logic        oob_w;
    logic [7:0]  byte_w;
    logic        on_w;
    logic        vs_fall_w;
    logic [11:0] pix_d;
    logic        unused_ctrl;

    // S1 sideband
    logic [9:0]  vram_addr_q;
    logic [1:0]  byte_sel_q1, byte_sel_q2;
    logic [3:0]  grow_q1, grow_q2;
    logic [2:0]  bit_q1, bit_q2, bit_q3;
    logic        oob_q1, oob_q2, oob_q3;
    logic        blank_q1, blank_q2, blank_q3;
    logic        hs_q1, hs_q2, hs_q3, hs_q;
    logic        vs_q1, vs_q2, vs_q3, vs_q;
    logic        inv_q3;
    logic [10:0] font_addr_q;
    logic [11:0] pix_q;
    logic [11:0] fg_q, bg_q;
    logic        vs_prev_q;
    logic        toggle_q;

    assign col_w  = draw_x[9:3];
    assign row_w  = draw_y[9:4];
    // row*80 as shifts; out-of-range rows may wrap but are masked by oob
    assign idx_w  = {row_w, 6'b0} + {2'b0, row_w, 4'b0} + {5'b0, col_w};
    assign oob_w  = (32'(col_w) >= COLS) || (32'(row_w) >= ROWS);
    assign byte_w = vram_rdata[{byte_sel_q2, 3'b000} +: 8];
    assign on_w   = font_data[~bit_q3] ^ inv_q3;
    assign vs_fall_w = vs_prev_q & ~vs_in;
    assign pix_d  = (!blank_q3 || oob_q3) ? 12'h000 : (on_w ? fg_q : bg_q);
    assign unused_ctrl = ^{ctrl_reg[31:25], ctrl_reg[0]};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            vram_addr_q <= '0;
            byte_sel_q1 <= '0;
            byte_sel_q2 <= '0;
            grow_q1     <= '0;
            grow_q2     <= '0;
            bit_q1      <= '0;
            bit_q2      <= '0;
            bit_q3      <= '0;
            oob_q1      <= 1'b0;
            oob_q2      <= 1'b0;
            oob_q3      <= 1'b0;
            blank_q1    <= 1'b0;
            blank_q2    <= 1'b0;
            blank_q3    <= 1'b0;
            hs_q1       <= 1'b1;
            hs_q2       <= 1'b1;
            hs_q3       <= 1'b1;
            hs_q        <= 1'b1;
            vs_q1       <= 1'b1;
            vs_q2       <= 1'b1;
            vs_q3       <= 1'b1;
            vs_q        <= 1'b1;
            inv_q3      <= 1'b0;
            font_addr_q <= '0;
            pix_q       <= '0;
            fg_q        <= '0;
            bg_q        <= '0;
            vs_prev_q   <= 1'b1;
            toggle_q    <= 1'b0;
        end else begin
            vram_addr_q <= oob_w ? 10'd0 : idx_w[11:2];
            byte_sel_q1 <= idx_w[1:0];
            grow_q1     <= draw_y[3:0];
            bit_q1      <= draw_x[2:0];
            oob_q1      <= oob_w;
            blank_q1    <= blank_in;
            hs_q1       <= hs_in;
            vs_q1       <= vs_in;

            byte_sel_q2 <= byte_sel_q1;
            grow_q2     <= grow_q1;
            bit_q2      <= bit_q1;
            oob_q2      <= oob_q1;
            blank_q2    <= blank_q1;
            hs_q2       <= hs_q1;
            vs_q2       <= vs_q1;

            font_addr_q <= {byte_w[6:0], grow_q2};
            inv_q3      <= byte_w[7];
            bit_q3      <= bit_q2;
            oob_q3      <= oob_q2;
            blank_q3    <= blank_q2;
            hs_q3       <= hs_q2;
            vs_q3       <= vs_q2;

            pix_q       <= pix_d;
            hs_q        <= hs_q3;
            vs_q        <= vs_q3;

            // S4 above still sees the old palette on the latch cycle
            vs_prev_q   <= vs_in;
            if (vs_fall_w) begin
                fg_q     <= ctrl_reg[24:13];
                bg_q     <= ctrl_reg[12:1];
                toggle_q <= ~toggle_q;
            end
        end
    end

    assign vram_addr    = vram_addr_q;
    assign font_addr    = font_addr_q;
    assign red          = pix_q[11:8];
    assign green        = pix_q[7:4];
    assign blue         = pix_q[3:0];
    assign hs           = hs_q;
    assign vs           = vs_q;
    assign frame_toggle = toggle_q;

endmodule

// File: tb/tb_vga_text_pixel_pipe.sv
// Directed bench for vga_text_pixel_pipe with behavioural VRAM (1-cycle read) and combinational font ROM.
module tb_vga_text_pixel_pipe;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [9:0]  draw_x, draw_y;
    logic        blank_in, hs_in, vs_in;
    logic [9:0]  vram_addr;
    logic [31:0] vram_rdata;
    logic [31:0] ctrl_reg;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic [3:0]  red, green, blue;
    logic        hs, vs, frame_toggle;

    logic [31:0] vram [0:1023];
    logic [7:0]  font_mem [0:2047];

    int errors = 0;
    int checks = 0;
    logic ft_before;

    always #10 CLK = ~CLK;

    vga_text_pixel_pipe dut (
        .CLK(CLK), .RESET(RESET),
        .draw_x(draw_x), .draw_y(draw_y),
        .blank_in(blank_in), .hs_in(hs_in), .vs_in(vs_in),
        .vram_addr(vram_addr), .vram_rdata(vram_rdata),
        .ctrl_reg(ctrl_reg),
        .font_addr(font_addr), .font_data(font_data),
        .red(red), .green(green), .blue(blue),
        .hs(hs), .vs(vs), .frame_toggle(frame_toggle)
    );

    always @(posedge CLK) vram_rdata <= vram[vram_addr];
    assign font_data = font_mem[font_addr];

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic vs_pulse();
        vs_in = 1'b0;
        tick(1);
        vs_in = 1'b1;
        tick(1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) vram[i] = 32'h0;
        for (int i = 0; i < 2048; i++) font_mem[i] = 8'h00;
        vram[0]  = 32'h0000_0041;
        vram[1]  = 32'h0000_00C1;
        vram[41] = 32'h3322_4211;
        font_mem[11'h413] = 8'b0001_1000;

        RESET = 1'b0;
        draw_x = '0; draw_y = '0;
        blank_in = 1'b1; hs_in = 1'b1; vs_in = 1'b1;
        ctrl_reg = 32'h01FF_E000;
        vram_rdata = '0;

        // Inputs toggling under reset must not reach the outputs
        #3;
        for (int k = 0; k < 3; k++) begin
            hs_in = k[0]; vs_in = ~k[0]; blank_in = k[0]; draw_x = 10'(k * 3);
            tick(1);
            check("rst_rgb", {20'h0, red, green, blue}, 32'h0);
            check("rst_hs", {31'h0, hs}, 32'h1);
            check("rst_vs", {31'h0, vs}, 32'h1);
            check("rst_ft", {31'h0, frame_toggle}, 32'h0);
        end
        check("rst_vaddr", {22'h0, vram_addr}, 32'h0);

        // Release with hs_in low: hs follows exactly 4 CLK later
        draw_x = 10'd0; draw_y = 10'd0; blank_in = 1'b1; vs_in = 1'b1; hs_in = 1'b0;
        RESET = 1'b1;
        tick(3);
        check("rel_hs_3clk", {31'h0, hs}, 32'h1);
        tick(1);
        check("rel_hs_4clk", {31'h0, hs}, 32'h0);
        hs_in = 1'b1;
        tick(4);

        // Address map: col 5, row 2 -> idx 165 -> word 41, byte 1 (0x42)
        draw_x = 10'd40; draw_y = 10'd32;
        tick(1);
        check("addr_word", {22'h0, vram_addr}, 32'd41);
        tick(2);
        check("addr_font_byte1", {21'h0, font_addr}, 32'h420);

        // Last visible cell: idx 2399 -> word 599
        draw_x = 10'd639; draw_y = 10'd479;
        tick(1);
        check("addr_last", {22'h0, vram_addr}, 32'd599);

        // Palette latch fg=FFF bg=000
        ft_before = frame_toggle;
        vs_pulse();
        check("ft_flip1", {31'h0, frame_toggle}, {31'h0, ~ft_before});

        draw_x = 10'd3; draw_y = 10'd3;
        tick(4);
        check("glyph_on", {20'h0, red, green, blue}, 32'hFFF);
        draw_x = 10'd0;
        tick(4);
        check("glyph_off", {20'h0, red, green, blue}, 32'h000);

        // Inverse glyph with fg=F00 bg=00F
        ctrl_reg = 32'h01E0_001E;
        vs_pulse();
        draw_x = 10'd35;
        tick(4);
        check("inv_on_pixel", {20'h0, red, green, blue}, 32'h00F);
        draw_x = 10'd32;
        tick(4);
        check("inv_off_pixel", {20'h0, red, green, blue}, 32'hF00);

        // Mid-frame ctrl write must not show until the next latch
        ctrl_reg = 32'h001E_0000;
        tick(4);
        check("tear_hold", {20'h0, red, green, blue}, 32'hF00);
        ft_before = frame_toggle;
        vs_in = 1'b0;
        tick(1);
        check("tear_latch_cycle_old", {20'h0, red, green, blue}, 32'hF00);
        check("tear_ft_flip", {31'h0, frame_toggle}, {31'h0, ~ft_before});
        vs_in = 1'b1;
        tick(1);
        check("tear_new_palette", {20'h0, red, green, blue}, 32'h0F0);
        tick(4);
        check("tear_ft_once", {31'h0, frame_toggle}, {31'h0, ~ft_before});
        check("tear_new_steady", {20'h0, red, green, blue}, 32'h0F0);

        // Blank and out-of-bounds masking
        draw_x = 10'd3; draw_y = 10'd3;
        tick(4);
        check("vis_base", {20'h0, red, green, blue}, 32'h0F0);
        blank_in = 1'b0;
        tick(4);
        check("blank_black", {20'h0, red, green, blue}, 32'h000);
        blank_in = 1'b1;
        draw_y = 10'd480;
        tick(1);
        check("oob_row_addr", {22'h0, vram_addr}, 32'h0);
        tick(3);
        check("oob_row_black", {20'h0, red, green, blue}, 32'h000);
        draw_y = 10'd3; draw_x = 10'd640;
        tick(1);
        check("oob_col_addr", {22'h0, vram_addr}, 32'h0);
        tick(3);
        check("oob_col_black", {20'h0, red, green, blue}, 32'h000);

        // Single-cycle hs pulse aligned with its own pixel
        draw_x = 10'd0;
        tick(4);
        hs_in = 1'b0; draw_x = 10'd3;
        tick(1);
        hs_in = 1'b1; draw_x = 10'd0;
        tick(2);
        check("hs_pulse_early", {31'h0, hs}, 32'h1);
        check("rgb_pulse_early", {20'h0, red, green, blue}, 32'h000);
        tick(1);
        check("hs_pulse_at4", {31'h0, hs}, 32'h0);
        check("rgb_pulse_at4", {20'h0, red, green, blue}, 32'h0F0);
        tick(1);
        check("hs_pulse_late", {31'h0, hs}, 32'h1);
        check("rgb_pulse_late", {20'h0, red, green, blue}, 32'h000);

        // Asynchronous reset mid-frame
        draw_x = 10'd3; hs_in = 1'b0;
        tick(4);
        #2;
        RESET = 1'b0;
        #1;
        check("mid_rst_rgb", {20'h0, red, green, blue}, 32'h000);
        check("mid_rst_hs", {31'h0, hs}, 32'h1);
        check("mid_rst_ft", {31'h0, frame_toggle}, 32'h0);
        check("mid_rst_font", {21'h0, font_addr}, 32'h0);
        tick(1);
        RESET = 1'b1;
        tick(3);
        check("mid_rel_hs_3clk", {31'h0, hs}, 32'h1);
        tick(1);
        check("mid_rel_hs_4clk", {31'h0, hs}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_text_pixel_pipe.md
Name: vga_text_pixel_pipe

Overview:
Rendering stage directly downstream of the text-mode VRAM/control register block. It takes DrawX/DrawY/blank/hs/vs from vga_controller and fetches the VRAM word for the current character. It looks up the glyph row in font_rom and drives the 4-bit RGB and delayed sync signals to the VGA pins. The palette is latched once per frame from the control register so mid-frame writes never tear.

Parameters:
COLS, 80, characters per row
ROWS, 30, character rows
LAT, 4, fixed CLK latency from DrawX/DrawY sample to RGB/hs/vs output (documentation only; not overridable)

Ports:
CLK  in  1  50 MHz system clock, shared with Avalon and vga_controller
RESET  in  1  asynchronous, active-low reset
draw_x  in  10  pixel column from vga_controller
draw_y  in  10  pixel row from vga_controller
blank_in  in  1  active-low blanking (0 = blank)
hs_in  in  1  horizontal sync, active-low
vs_in  in  1  vertical sync, active-low
vram_addr  out  10  word address to VRAM read port (0..599)
vram_rdata  in  32  VRAM read data, valid one CLK after vram_addr
ctrl_reg  in  32  control register word (FGD_R[24:21] FGD_G[20:17] FGD_B[16:13] BKG_R[12:9] BKG_G[8:5] BKG_B[4:1])
font_addr  out  11  font_rom address {code[6:0], glyph_row[3:0]}
font_data  in  8  font_rom row bits, combinational from font_addr, bit 7 = leftmost pixel
red, green, blue  out  4 each  VGA colour
hs, vs  out  1 each  delayed syncs, aligned with RGB
frame_toggle  out  1  flips on every palette latch; feeds the VSYNC status bit

Behaviour:
- Reset (RESET=0, async): vram_addr=0, font_addr=0, red/green/blue=0, hs=1, vs=1, frame_toggle=0, palette fg=bg=0x000, all pipeline sideband registers cleared. blank_q is held 0 so output is black until the pipeline refills. Release is sampled on CLK rise.
- The pipeline advances every CLK; there is no enable. A pixel_clk is held for 2 CLK, so each pixel is processed twice with identical results.
- Edge 1 (S1):
  - col=draw_x[9:3], row=draw_y[9:4], idx=row*80+col, computed as (row<<6)+(row<<4)+col in 12 bits.
  - vram_addr<=idx[11:2]; byte_sel<=idx[1:0]; grow<=draw_y[3:0]; bit_idx<=draw_x[2:0].
  - oob<=(col>=COLS)|(row>=ROWS). When oob, vram_addr<=0.
  - blank/hs/vs are captured.
- Edge 2 (S2): sideband is shifted. vram_rdata is valid in the cycle after this edge.
- Edge 3 (S3):
  - byte=vram_rdata[8*byte_sel+:8]; font_addr<={byte[6:0],grow}; inv<=byte[7]; sideband is shifted.
  - Byte 0 is the leftmost character of a word.
- Edge 4 (S4):
  - on=font_data[7-bit_idx]^inv.
  - Colour = on ? fg : bg.
  - RGB is forced to 0 if blank_q==0 or oob_q==1.
  - hs/vs<=S3 copies.
  - Total latency is exactly 4 CLK for RGB, hs and vs.
- Palette latch:
  - On the CLK where vs_in is sampled falling (prev=1, now=0), fg<=ctrl_reg[24:13] and bg<=ctrl_reg[12:1], and frame_toggle flips.
  - The new palette applies to S4 from the next cycle onward, which is inside vsync, so no visible pixel uses mixed colours.
  - ctrl_reg changes at any other time have no visible effect until the next latch.
- Simultaneous events: a vs falling edge concurrent with a pixel in S4 uses the old palette on that cycle.
- Reset mid-frame: outputs go to reset values immediately. The pipeline restarts, and the first valid RGB appears 4 CLK after release.
- No handshake exists. VRAM is assumed to serve reads every cycle, with Avalon arbitration handled in the register block.

Test Plan:
- Reset: hold RESET=0, toggle inputs -> RGB=0, hs=vs=1, frame_toggle=0. Release; 4 CLK later outputs follow the inputs.
- Address map: draw_x=8*5, draw_y=16*2 -> vram_addr=(2*80+5)>>2=41 one CLK later, and byte_sel=1 selects vram_rdata[15:8].
- Glyph pixel:
  - Setup: VRAM word 0=0x00000041, font_data for addr {0x41,row 3}=0b00011000; vs falling latches ctrl fg=0xFFF, bg=0x000.
  - draw_x=3, draw_y=3 -> RGB=F,F,F at +4 CLK.
  - draw_x=0 -> RGB=0,0,0.
- Inverse: VRAM byte=0xC1 (IV=1, same glyph) with fg=0xF00, bg=0x00F -> draw_x=3 outputs 0,0,F; draw_x=0 outputs F,0,0.
- Palette tearing: change ctrl_reg mid-frame to fg=0x0F0 -> active-area RGB stays at the old fg. After the vs_in falling edge the next frame shows 0,F,0 and frame_toggle has flipped exactly once.
- Blank/oob/latency: blank_in=0 or draw_y=480 -> RGB=0. A single-cycle hs_in pulse appears on hs exactly 4 CLK later, aligned with the RGB of the same sample.
